hls_exec_profiler: RTL and testbench
====================================

Name: hls_exec_profiler

Overview:
- Synthesizable run-time profiler for one HLS-generated block.
- Observes the block's ap_start/ap_ready/ap_done/ap_continue handshake and its one-hot FSM state vector.
- Accumulates transaction counts, busy cycles, latency, loop entries, iteration (back-edge) counts and loop cycles.
- Sits beside the profiled block, driven from the same clock; purely passive, never drives the block.

Parameters:
NUM_STATES, 463, width of the one-hot FSM state vector and of every state mask.
CNT_W, 32, width of every counter output.

Ports:
clock  in  1  sole clock; all logic on its rising edge.
reset  in  1  synchronous, active-high reset.
finish  in  1  end-of-run; freezes all statistics.
ap_start  in  1  profiled block start.
ap_ready  in  1  profiled block ready.
ap_done  in  1  profiled block done.
ap_continue  in  1  profiled block continue; tie to 1 when the block has none.
cur_state  in  NUM_STATES  profiled FSM one-hot state register.
pre_loop_state  in  NUM_STATES  mask of the state(s) preceding loop entry.
iter_start_state  in  NUM_STATES  mask of the first state of an iteration.
iter_end_state  in  NUM_STATES  mask of the last state of an iteration.
quit_loop_state  in  NUM_STATES  mask of the exit-test state.
post_loop_state  in  NUM_STATES  mask of the state(s) after loop exit.
one_state_loop  in  1  1 = loop body is a single state.
mod_state  out  2  0 IDLE, 1 BUSY, 2 WAIT_CONT.
mod_start_cnt, mod_done_cnt, mod_busy_cycles, mod_last_latency  out  CNT_W each  module statistics.
loop_active  out  1  loop currently executing.
loop_entry_cnt, loop_iter_cnt, loop_cycles, loop_last_trip  out  CNT_W each  loop statistics.
frozen  out  1  statistics frozen by finish.

Behaviour:
- Reset (synchronous, active-high) sets every output and internal register to 0, including prev_state and the latency accumulator. Reset mid-transaction or mid-loop discards all partial state.
- in_X means (cur_state & X_mask) != 0. prev_in_X is the same test applied to prev_state, the registered cur_state of the previous cycle.
- Counters saturate at all-ones and never wrap.
- Module FSM:
  - IDLE with ap_start=1: start transaction. mod_start_cnt+1, mod_busy_cycles+1, lat<=1, go to BUSY.
  - If ap_done=1 in that same start cycle: latency is 1, done rules below apply directly, and the FSM never enters BUSY.
  - BUSY, each cycle: mod_busy_cycles+1.
  - BUSY without ap_done: lat+1.
  - BUSY with ap_done: mod_done_cnt+1, mod_last_latency<=lat+1 (start cycle through done cycle, inclusive).
    - If ap_continue=1: return to IDLE. If ap_start and ap_ready are also 1, start a new transaction instead (count it, lat<=1, stay BUSY).
    - If ap_continue=0: go to WAIT_CONT.
  - WAIT_CONT: ap_done is ignored; on ap_continue=1 go to IDLE. No busy cycles are counted here.
- Loop tracking:
  - Entry: !loop_active && prev_in_pre && in_iter_start. Sets loop_active, loop_entry_cnt+1, clears the per-activation trip counter.
  - Back-edge: loop_active && prev_in_iter_end && in_iter_start && (one_state_loop || cur_state != prev_state). Increments loop_iter_cnt and the trip counter. The cur_state != prev_state term means a stalled multi-state FSM is never miscounted.
  - Exit: loop_active && prev_in_quit && in_post. Clears loop_active and sets loop_last_trip<=trip.
  - Exit has priority over a back-edge in the same cycle. Entry and exit in the same cycle: exit is processed first, then the re-entry.
  - loop_cycles increments every cycle loop_active=1 (entry cycle inclusive, exit cycle exclusive).
- Finish:
  - finish=1 at a rising edge sets frozen.
  - While frozen, all counters, mod_state and loop_active hold. frozen clears only on reset.
  - Updates in the cycle where finish is first sampled are still applied.

Test Plan:
- Bench uses NUM_STATES=8, CNT_W=16.
- Handshake: ap_start pulse at cycle 0, ap_done at cycle 3, ap_continue=1 -> mod_start_cnt=1, mod_done_cnt=1, mod_last_latency=4, mod_busy_cycles=4, mod_state=0.
- Back-pressure: done at cycle 2 with ap_continue=0, continue at cycle 6 -> mod_state=2 during cycles 3-6, then 0; mod_busy_cycles=3.
- Seq loop with pre=bit1, iter_start=quit=bit2, iter_end=bit3, post=bit4: walk 1,2,3,2,3,2,3,2,4 -> loop_entry_cnt=1, loop_iter_cnt=3, loop_last_trip=3, loop_cycles=7.
- One-state loop with start=end=quit=bit2, one_state_loop=1: state 2 held 5 cycles, then 4 -> loop_iter_cnt=4, loop_last_trip=4.
- Stall: one_state_loop=0 and state 3 held 3 cycles before returning to 2 -> only 1 back-edge counted.
- finish=1 at cycle 10, then further ap_start pulses -> counters unchanged and frozen=1. Then reset=1 -> all outputs 0.

Source files
------------

// File: rtl/hls_exec_profiler.sv
// Passive run-time profiler for one HLS-generated block.
// Watches the ap_* handshake and the one-hot FSM state vector, and keeps
// saturating statistics for transactions and for a single tracked loop.
// A finish pulse freezes every statistic until the next reset.
module hls_exec_profiler #(
    parameter int NUM_STATES = 463,
    parameter int CNT_W      = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  finish,
    input  logic                  ap_start,
    input  logic                  ap_ready,
    input  logic                  ap_done,
    input  logic                  ap_continue,
    input  logic [NUM_STATES-1:0] cur_state,
    input  logic [NUM_STATES-1:0] pre_loop_state,
    input  logic [NUM_STATES-1:0] iter_start_state,
    input  logic [NUM_STATES-1:0] iter_end_state,
    input  logic [NUM_STATES-1:0] quit_loop_state,
    input  logic [NUM_STATES-1:0] post_loop_state,
    input  logic                  one_state_loop,
    output logic [1:0]            mod_state,
    output logic [CNT_W-1:0]      mod_start_cnt,
    output logic [CNT_W-1:0]      mod_done_cnt,
    output logic [CNT_W-1:0]      mod_busy_cycles,
    output logic [CNT_W-1:0]      mod_last_latency,
    output logic                  loop_active,
    output logic [CNT_W-1:0]      loop_entry_cnt,
    output logic [CNT_W-1:0]      loop_iter_cnt,
    output logic [CNT_W-1:0]      loop_cycles,
    output logic [CNT_W-1:0]      loop_last_trip,
    output logic                  frozen
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_WAIT = 2'd2
    } mod_state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    mod_state_t            state_reg, state_next;
    logic [CNT_W-1:0]      start_cnt_reg, done_cnt_reg, busy_cnt_reg;
    logic [CNT_W-1:0]      lat_reg, lat_next, last_lat_reg, last_lat_next;
    logic                  start_inc, done_inc, busy_inc;

    logic [NUM_STATES-1:0] prev_state_reg;
    logic                  loop_active_reg, loop_active_next;
    logic [CNT_W-1:0]      entry_cnt_reg, iter_cnt_reg, cycles_cnt_reg;
    logic [CNT_W-1:0]      trip_reg, last_trip_reg;
    logic                  frozen_reg;

    logic in_pre_prev, in_start, in_end_prev, in_quit_prev, in_post;
    logic loop_entry, loop_back, loop_exit;

    // Transaction FSM state register; holds while frozen.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else if (!frozen_reg) begin
            state_reg <= state_next;
        end
    end

    // Transaction FSM next state and per-cycle counter events.
    always_comb begin
        state_next    = state_reg;
        start_inc     = 1'b0;
        done_inc      = 1'b0;
        busy_inc      = 1'b0;
        lat_next      = lat_reg;
        last_lat_next = last_lat_reg;
        case (state_reg)
            ST_IDLE: begin
                if (ap_start) begin
                    start_inc = 1'b1;
                    busy_inc  = 1'b1;
                    lat_next  = CNT_ONE;
                    if (ap_done) begin
                        // Single-cycle transaction: never visits BUSY.
                        done_inc      = 1'b1;
                        last_lat_next = CNT_ONE;
                        state_next    = ap_continue ? ST_IDLE : ST_WAIT;
                    end else begin
                        state_next = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                busy_inc = 1'b1;
                if (!ap_done) begin
                    lat_next = sat_inc(lat_reg);
                end else begin
                    done_inc      = 1'b1;
                    last_lat_next = sat_inc(lat_reg);
                    if (!ap_continue) begin
                        state_next = ST_WAIT;
                    end else if (ap_start && ap_ready) begin
                        // Back-to-back transaction starts in the done cycle.
                        start_inc  = 1'b1;
                        lat_next   = CNT_ONE;
                        state_next = ST_BUSY;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_WAIT: begin
                if (ap_continue) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Loop event detection from current and previous one-hot state.
    always_comb begin
        in_pre_prev  = |(prev_state_reg & pre_loop_state);
        in_start     = |(cur_state & iter_start_state);
        in_end_prev  = |(prev_state_reg & iter_end_state);
        in_quit_prev = |(prev_state_reg & quit_loop_state);
        in_post      = |(cur_state & post_loop_state);
        loop_exit    = loop_active_reg && in_quit_prev && in_post;
        // The state-change term keeps a stalled multi-state body from
        // being counted as repeated iterations.
        loop_back    = loop_active_reg && !loop_exit && in_end_prev && in_start
                       && (one_state_loop || (cur_state != prev_state_reg));
        // Exit is applied before entry, so an exit can immediately re-enter.
        loop_entry   = (!loop_active_reg || loop_exit) && in_pre_prev && in_start;
        loop_active_next = loop_entry || (loop_active_reg && !loop_exit);
    end

    // Statistic registers; frozen after finish, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            start_cnt_reg   <= '0;
            done_cnt_reg    <= '0;
            busy_cnt_reg    <= '0;
            lat_reg         <= '0;
            last_lat_reg    <= '0;
            prev_state_reg  <= '0;
            loop_active_reg <= 1'b0;
            entry_cnt_reg   <= '0;
            iter_cnt_reg    <= '0;
            cycles_cnt_reg  <= '0;
            trip_reg        <= '0;
            last_trip_reg   <= '0;
            frozen_reg      <= 1'b0;
        end else if (!frozen_reg) begin
            if (start_inc) start_cnt_reg <= sat_inc(start_cnt_reg);
            if (done_inc)  done_cnt_reg  <= sat_inc(done_cnt_reg);
            if (busy_inc)  busy_cnt_reg  <= sat_inc(busy_cnt_reg);
            lat_reg         <= lat_next;
            last_lat_reg    <= last_lat_next;
            prev_state_reg  <= cur_state;
            loop_active_reg <= loop_active_next;
            if (loop_entry)       entry_cnt_reg  <= sat_inc(entry_cnt_reg);
            if (loop_back)        iter_cnt_reg   <= sat_inc(iter_cnt_reg);
            if (loop_active_next) cycles_cnt_reg <= sat_inc(cycles_cnt_reg);
            if (loop_entry)       trip_reg       <= '0;
            else if (loop_back)   trip_reg       <= sat_inc(trip_reg);
            if (loop_exit)        last_trip_reg  <= trip_reg;
            if (finish)           frozen_reg     <= 1'b1;
        end
    end

    assign mod_state        = state_reg;
    assign mod_start_cnt    = start_cnt_reg;
    assign mod_done_cnt     = done_cnt_reg;
    assign mod_busy_cycles  = busy_cnt_reg;
    assign mod_last_latency = last_lat_reg;
    assign loop_active      = loop_active_reg;
    assign loop_entry_cnt   = entry_cnt_reg;
    assign loop_iter_cnt    = iter_cnt_reg;
    assign loop_cycles      = cycles_cnt_reg;
    assign loop_last_trip   = last_trip_reg;
    assign frozen           = frozen_reg;

endmodule

// File: tb/tb_hls_exec_profiler.sv
// Scoreboard bench for hls_exec_profiler: directed scenarios plus random
// traffic, each cycle's expected outputs queued from a behavioural model.
module tb_hls_exec_profiler;

    localparam int NS = 8;
    localparam int CW = 16;
    localparam int SAT = 65535;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset, finish, ap_start, ap_ready, ap_done, ap_continue;
    logic          one_state_loop;
    logic [NS-1:0] cur_state, pre_m, start_m, end_m, quit_m, post_m;
    logic [1:0]    mod_state;
    logic [CW-1:0] mod_start_cnt, mod_done_cnt, mod_busy_cycles, mod_last_latency;
    logic          loop_active, frozen;
    logic [CW-1:0] loop_entry_cnt, loop_iter_cnt, loop_cycles, loop_last_trip;

    hls_exec_profiler #(.NUM_STATES(NS), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .finish(finish),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
        .ap_continue(ap_continue), .cur_state(cur_state),
        .pre_loop_state(pre_m), .iter_start_state(start_m),
        .iter_end_state(end_m), .quit_loop_state(quit_m),
        .post_loop_state(post_m), .one_state_loop(one_state_loop),
        .mod_state(mod_state), .mod_start_cnt(mod_start_cnt),
        .mod_done_cnt(mod_done_cnt), .mod_busy_cycles(mod_busy_cycles),
        .mod_last_latency(mod_last_latency), .loop_active(loop_active),
        .loop_entry_cnt(loop_entry_cnt), .loop_iter_cnt(loop_iter_cnt),
        .loop_cycles(loop_cycles), .loop_last_trip(loop_last_trip),
        .frozen(frozen)
    );

    typedef struct packed {
        logic [1:0]    ms;
        logic [CW-1:0] sc, dc, bc, ll;
        logic          la;
        logic [CW-1:0] ec, ic, lc, lt;
        logic          fr;
    } snap_t;

    snap_t act_snap, exp_snap;
    assign act_snap = {mod_state, mod_start_cnt, mod_done_cnt, mod_busy_cycles,
                       mod_last_latency, loop_active, loop_entry_cnt, loop_iter_cnt,
                       loop_cycles, loop_last_trip, frozen};

    snap_t sb[$];
    int checks = 0;
    int passed = 0;
    longint cyc = 0;

    // Reference model state: plain integers, updated rule by rule.
    int m_st, m_sc, m_dc, m_bc, m_ll, m_lat;
    int m_ec, m_ic, m_lc, m_lt, m_trip;
    bit m_la, m_fr;
    logic [NS-1:0] m_prev;

    function automatic int sat(input int x);
        return (x >= SAT) ? SAT : x + 1;
    endfunction

    function automatic bit hit(input logic [NS-1:0] v, input logic [NS-1:0] m);
        return (v & m) != '0;
    endfunction

    task automatic model_step();
        bit exited, back;
        if (reset) begin
            m_st = 0; m_sc = 0; m_dc = 0; m_bc = 0; m_ll = 0; m_lat = 0;
            m_ec = 0; m_ic = 0; m_lc = 0; m_lt = 0; m_trip = 0;
            m_la = 0; m_fr = 0; m_prev = '0;
        end else if (!m_fr) begin
            case (m_st)
                0: if (ap_start) begin
                    m_sc = sat(m_sc); m_bc = sat(m_bc); m_lat = 1;
                    if (ap_done) begin
                        m_dc = sat(m_dc); m_ll = 1;
                        m_st = ap_continue ? 0 : 2;
                    end else m_st = 1;
                end
                1: begin
                    m_bc = sat(m_bc);
                    if (!ap_done) m_lat = sat(m_lat);
                    else begin
                        m_dc = sat(m_dc); m_ll = sat(m_lat);
                        if (!ap_continue) m_st = 2;
                        else if (ap_start && ap_ready) begin m_sc = sat(m_sc); m_lat = 1; end
                        else m_st = 0;
                    end
                end
                default: if (ap_continue) m_st = 0;
            endcase
            exited = m_la && hit(m_prev, quit_m) && hit(cur_state, post_m);
            back = m_la && !exited && hit(m_prev, end_m) && hit(cur_state, start_m)
                   && (one_state_loop || cur_state != m_prev);
            if (exited) begin m_la = 0; m_lt = m_trip; end
            if (back) begin m_ic = sat(m_ic); m_trip = sat(m_trip); end
            if (!m_la && hit(m_prev, pre_m) && hit(cur_state, start_m)) begin
                m_la = 1; m_ec = sat(m_ec); m_trip = 0;
            end
            if (m_la) m_lc = sat(m_lc);
            m_prev = cur_state;
            if (finish) m_fr = 1;
        end
    endtask

    function automatic snap_t model_snap();
        return {2'(m_st), 16'(m_sc), 16'(m_dc), 16'(m_bc), 16'(m_ll), m_la,
                16'(m_ec), 16'(m_ic), 16'(m_lc), 16'(m_lt), m_fr};
    endfunction

    // Monitor: compare every queued expectation away from the active edge.
    always @(negedge clock) begin
        if (sb.size() != 0) begin
            exp_snap = sb.pop_front();
            checks++;
            if (act_snap !== exp_snap)
                $display("FAIL snapshot cyc=%0d actual=%h required=%h", cyc, act_snap, exp_snap);
            else
                passed++;
        end
    end

    task automatic tick();
        model_step();
        @(posedge clock);
        cyc++;
        sb.push_back(model_snap());
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) $display("FAIL %s actual=%0d required=%0d", name, a, e);
        else passed++;
    endtask

    task automatic idle_inputs();
        reset = 0; finish = 0; ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 1;
    endtask

    task automatic do_reset();
        idle_inputs();
        cur_state = '0;
        reset = 1; tick(); tick();
        reset = 0;
    endtask

    task automatic set_masks(input int p, input int s, input int e, input int q, input int o);
        pre_m = '0; start_m = '0; end_m = '0; quit_m = '0; post_m = '0;
        pre_m[p] = 1'b1; start_m[s] = 1'b1; end_m[e] = 1'b1; quit_m[q] = 1'b1; post_m[o] = 1'b1;
    endtask

    task automatic go_state(input int b);
        cur_state = '0;
        cur_state[b] = 1'b1;
        tick();
    endtask

    int w_seq[9]   = '{1, 2, 3, 2, 3, 2, 3, 2, 4};
    int w_one[7]   = '{1, 2, 2, 2, 2, 2, 4};
    int w_stall[7] = '{1, 2, 3, 3, 3, 2, 4};

    initial begin
        int pb, sbit, eb, qb, ob, r;
        idle_inputs();
        one_state_loop = 0;
        cur_state = '0;
        set_masks(1, 2, 3, 2, 4);

        // Reset state
        do_reset();
        check("reset_state", 32'(mod_state), 0);
        check("reset_start_cnt", 32'(mod_start_cnt), 0);
        check("reset_frozen", 32'(frozen), 0);

        // Basic handshake
        for (int c = 0; c < 4; c++) begin
            ap_start = (c == 0); ap_done = (c == 3);
            tick();
        end
        idle_inputs(); tick();
        check("hs_start_cnt", 32'(mod_start_cnt), 1);
        check("hs_done_cnt", 32'(mod_done_cnt), 1);
        check("hs_last_latency", 32'(mod_last_latency), 4);
        check("hs_busy_cycles", 32'(mod_busy_cycles), 4);
        check("hs_state", 32'(mod_state), 0);
        $display("txn handshake: latency=%0d busy=%0d", mod_last_latency, mod_busy_cycles);

        // Back-pressure through WAIT_CONT
        do_reset();
        for (int c = 0; c < 8; c++) begin
            ap_start = (c == 0); ap_done = (c == 2);
            ap_continue = !(c >= 2 && c <= 5);
            tick();
            if (c >= 2 && c <= 5) check("bp_wait_state", 32'(mod_state), 2);
            if (c == 6) check("bp_idle_state", 32'(mod_state), 0);
        end
        check("bp_busy_cycles", 32'(mod_busy_cycles), 3);
        $display("txn backpressure: busy=%0d", mod_busy_cycles);

        // Multi-state loop
        do_reset();
        set_masks(1, 2, 3, 2, 4); one_state_loop = 0;
        foreach (w_seq[i]) go_state(w_seq[i]);
        check("seq_entry_cnt", 32'(loop_entry_cnt), 1);
        check("seq_iter_cnt", 32'(loop_iter_cnt), 3);
        check("seq_last_trip", 32'(loop_last_trip), 3);
        check("seq_loop_cycles", 32'(loop_cycles), 7);
        check("seq_loop_active", 32'(loop_active), 0);
        $display("txn seq loop: iters=%0d cycles=%0d", loop_iter_cnt, loop_cycles);

        // Single-state loop
        do_reset();
        set_masks(1, 2, 2, 2, 4); one_state_loop = 1;
        foreach (w_one[i]) go_state(w_one[i]);
        check("one_iter_cnt", 32'(loop_iter_cnt), 4);
        check("one_last_trip", 32'(loop_last_trip), 4);
        $display("txn one-state loop: iters=%0d", loop_iter_cnt);

        // Stalled iteration-end state
        do_reset();
        set_masks(1, 2, 3, 2, 4); one_state_loop = 0;
        foreach (w_stall[i]) go_state(w_stall[i]);
        check("stall_iter_cnt", 32'(loop_iter_cnt), 1);
        check("stall_last_trip", 32'(loop_last_trip), 1);
        $display("txn stall loop: iters=%0d", loop_iter_cnt);

        // Finish freezes statistics; updates in the finish cycle still land
        do_reset();
        cur_state = '0;
        for (int c = 0; c < 16; c++) begin
            ap_start = (c == 0) || (c == 10) || (c == 12) || (c == 14);
            ap_done = (c == 3) || (c == 13);
            ap_ready = 1;
            finish = (c == 10);
            tick();
        end
        idle_inputs();
        check("fin_frozen", 32'(frozen), 1);
        check("fin_start_cnt", 32'(mod_start_cnt), 2);
        check("fin_done_cnt", 32'(mod_done_cnt), 1);
        check("fin_busy_cycles", 32'(mod_busy_cycles), 5);
        check("fin_state", 32'(mod_state), 1);
        reset = 1; tick(); reset = 0;
        check("fin_reset_frozen", 32'(frozen), 0);
        check("fin_reset_start", 32'(mod_start_cnt), 0);
        check("fin_reset_busy", 32'(mod_busy_cycles), 0);
        check("fin_reset_state", 32'(mod_state), 0);
        $display("txn finish/reset: frozen=%0d", frozen);

        // Random traffic against the model
        for (int seg = 0; seg < 6; seg++) begin
            pb = $urandom_range(0, 7); sbit = $urandom_range(0, 7);
            eb = ($urandom_range(0, 2) == 0) ? sbit : $urandom_range(0, 7);
            qb = ($urandom_range(0, 1) == 0) ? sbit : eb;
            ob = $urandom_range(0, 7);
            set_masks(pb, sbit, eb, qb, ob);
            one_state_loop = ($urandom_range(0, 1) == 1);
            for (int c = 0; c < 500; c++) begin
                ap_start    = ($urandom_range(0, 3) == 0);
                ap_ready    = ($urandom_range(0, 1) == 1);
                ap_done     = ($urandom_range(0, 2) == 0);
                ap_continue = ($urandom_range(0, 3) != 0);
                reset       = ($urandom_range(0, 299) == 0);
                finish      = (seg == 5) && (c == 400);
                r = $urandom_range(0, 9);
                if (r >= 3) begin
                    cur_state = '0;
                    case (r)
                        3: cur_state[pb] = 1'b1;
                        4, 5: cur_state[sbit] = 1'b1;
                        6: cur_state[eb] = 1'b1;
                        7: cur_state[qb] = 1'b1;
                        8: cur_state[ob] = 1'b1;
                        default: cur_state[$urandom_range(0, 7)] = 1'b1;
                    endcase
                end
                if (seg == 5 && c > 400) reset = 0;
                tick();
            end
            $display("txn random segment %0d: starts=%0d iters=%0d", seg, mod_start_cnt, loop_iter_cnt);
        end
        idle_inputs();
        reset = 1; tick(); reset = 0; tick();

        // Drain the scoreboard (bounded)
        for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clock);
        #1;
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
